// File: rtl/display_pkg.sv
// Shared types, constants and glyph decoder for the RPN seven-segment display driver.
package display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} dd_state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         N_DIGITS   = 8;
  localparam int         BCD_DIGITS = 5;

  // Active-low {g,f,e,d,c,b,a} glyph for a hex nibble.
  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    case (n)
      4'h0: seg_glyph = 7'h40;
      4'h1: seg_glyph = 7'h79;
      4'h2: seg_glyph = 7'h24;
      4'h3: seg_glyph = 7'h30;
      4'h4: seg_glyph = 7'h19;
      4'h5: seg_glyph = 7'h12;
      4'h6: seg_glyph = 7'h02;
      4'h7: seg_glyph = 7'h78;
      4'h8: seg_glyph = 7'h00;
      4'h9: seg_glyph = 7'h10;
      4'hA: seg_glyph = 7'h08;
      4'hB: seg_glyph = 7'h03;
      4'hC: seg_glyph = 7'h46;
      4'hD: seg_glyph = 7'h21;
      4'hE: seg_glyph = 7'h06;
      4'hF: seg_glyph = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble 16-bit binary to 5-digit BCD converter.
// Compiled only when RPN_DISPLAY_BCD_EN is defined.
`ifdef RPN_DISPLAY_BCD_EN
module bin2bcd_dd
  import display_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               value,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_DIGITS*4-1:0]   bcd
);

  dd_state_t                        r_state, w_next;
  logic [15:0]                      r_shadow, r_bin;
  logic [BCD_DIGITS-1:0][3:0]       r_bcd, w_adj;
  logic [3:0]                       r_iter;
  logic                             w_change;

  assign w_change = (value != r_shadow);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_change) w_next = SHIFT;
      SHIFT:   if (r_iter == 4'd15) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < BCD_DIGITS; i++)
      w_adj[i] = (r_bcd[i] >= 4'd5) ? r_bcd[i] + 4'd3 : r_bcd[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_iter   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_change) begin
          r_shadow <= value;
          r_bin    <= value;
          r_bcd    <= '0;
          r_iter   <= '0;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_iter         <= r_iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign bcd  = r_bcd;

endmodule
`endif

// File: rtl/rpn_display_driver.sv
// 8-digit multiplexed seven-segment driver for the RPN calculator.
// RPN_DISPLAY_BCD_EN selects decimal (double-dabble) display; otherwise hex.
module rpn_display_driver
  import display_pkg::*;
#(
  parameter int COUNT_MAX = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [2:0]  status,
  output logic        busy,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp
);

  localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int DW = $clog2(N_DIGITS);

  logic [CW-1:0]               r_cnt;
  logic [DW-1:0]               r_dig;
  logic [BCD_DIGITS-1:0][3:0]  r_buf;
  logic [7:0]                  r_anodes;
  logic [6:0]                  r_segments;
  logic [6:0]                  w_seg;

`ifdef RPN_DISPLAY_BCD_EN
  logic                        w_done;
  logic [BCD_DIGITS-1:0][3:0]  w_bcd;
  logic [N_DIGITS-1:0]         w_nz;

  bin2bcd_dd u_bcd (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .busy  (busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // w_nz[k]: some digit from k up to the top BCD digit is non-zero.
  always_comb begin
    w_nz = '0;
    w_nz[BCD_DIGITS-1] = |r_buf[BCD_DIGITS-1];
    for (int k = BCD_DIGITS - 2; k >= 0; k--)
      w_nz[k] = w_nz[k+1] | (|r_buf[k]);
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    w_seg = SEG_BLANK;
    if (r_dig == DW'(N_DIGITS - 1)) begin
      w_seg = seg_glyph({1'b0, status});
    end else if (r_dig < DW'(BCD_DIGITS)) begin
`ifdef RPN_DISPLAY_BCD_EN
      if (r_dig == '0 || w_nz[r_dig]) w_seg = seg_glyph(r_buf[r_dig]);
`else
      if (r_dig != DW'(BCD_DIGITS - 1)) w_seg = seg_glyph(r_buf[r_dig]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_dig      <= '0;
      r_buf      <= '0;
      r_anodes   <= 8'hFF;
      r_segments <= SEG_BLANK;
    end else begin
      if (r_cnt == CW'(COUNT_MAX - 1)) begin
        r_cnt <= '0;
        r_dig <= r_dig + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
`ifdef RPN_DISPLAY_BCD_EN
      if (w_done) r_buf <= w_bcd;
`else
      r_buf <= {4'h0, value};
`endif
      // Anode and segment registers share one edge, so no ghost cycle.
      r_anodes   <= ~(8'h01 << r_dig);
      r_segments <= w_seg;
    end
  end

  assign anodes   = r_anodes;
  assign segments = r_segments;
  assign dp       = 1'b1;

endmodule

// File: doc/rpn_display_driver.md
# rpn_display_driver

Downstream stage of the RPN calculator: consumes the calculator's 16-bit display value and 3-bit status and drives the board's 8-digit multiplexed seven-segment display (active-low anodes and segments). Contains an iterative double-dabble binary-to-BCD converter so results appear in decimal, plus a refresh scanner that time-multiplexes the eight digits. Display data is double-buffered, so a conversion in progress never tears the visible digits.

## Interface
- `COUNT_MAX`, default 100000: clock cycles each digit stays lit (1 kHz digit rate at 100 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous and active-high; all state clears on a rising `clk` edge while `reset`=1.
- `value`  in  16  number to show, treated as unsigned (calculator `ToDisplay`).
- `status`  in  3  calculator state index, shown on digit 7.
- `busy`  out  1  conversion in progress.
- `anodes`  out  8  digit enables, active-low; bit i selects digit i (digit 0 is rightmost).
- `segments`  out  7  {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low; constant 1.

## Operation
- **Reset values:** `anodes`=8'hFF, `segments`=7'h7F, `dp`=1, `busy`=0. Refresh counter=0, digit index=0, shadow register=0, display buffer=all-zero digits, FSM=IDLE.
- **Refresh counter:** counts 0..COUNT_MAX-1. On wrap, the digit index increments and wraps 7→0.
- **FSM IDLE:** when `value` ≠ shadow, latch `value` into the shadow and the shift register, clear the BCD register, and go to SHIFT.
- **FSM SHIFT:** 16 iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts {bcd, bin} left by 1. After the 16th iteration, go to DONE.
- **FSM DONE:** copy the 5 BCD digits into the display buffer and return to IDLE.
- `busy`=1 in SHIFT and DONE.
- Changes on `value` during SHIFT/DONE are ignored. On return to IDLE the comparison reruns, so the final `value` is always displayed.
- **Digit map:**
  - Digits 0–4 show BCD, with leading-zero blanking: digit 0 is never blanked; a higher digit is blank when it and all digits above it (up to digit 4) are zero.
  - Digits 5–6 are always blank.
  - Digit 7 shows the `status` glyph 0–7.
- **Glyphs, active-low:** 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E, blank=7'h7F.
- **Reset mid-conversion:** aborts the conversion; the display buffer returns to zeros.

## Timing
- `anodes` and `segments` are registered and lag the digit index by 1 cycle. Both change on the same edge, so there is no ghost cycle.
- **Conversion timing:** edge E0 samples the change. Edges E1–E16 shift. E17 commits the result (DONE→IDLE). `busy` is high for exactly 17 cycles, from after E0 until after E17.
- The new digits appear on `segments` after E18, provided that digit is selected.
- Back-to-back changes: the next conversion starts at the first IDLE cycle, 1 cycle after E17.
- A `status` change is visible within 1 cycle of the next digit-7 selection; it is not buffered.

## Configuration
- **`RPN_DISPLAY_BCD_EN` defined:** behaviour as above (decimal 0–65535 on digits 0–4).
- **`RPN_DISPLAY_BCD_EN` undefined:**
  - The converter and FSM are not compiled, and `busy` is tied to 0.
  - The display buffer loads the hex nibbles of `value` 1 cycle after `value` changes.
  - Digits 0–3 show hex glyphs, with no leading-zero blanking.
  - Digit 4 is blank.

## Structure
- **Package `display_pkg`:**
  - FSM enum {IDLE, SHIFT, DONE}
  - `SEG_BLANK` constant
  - 4-bit→7-bit glyph function
  - `N_DIGITS`=8
  - BCD digit count 5
- **Sub-module `bin2bcd_dd`:** owns the FSM, the shift/BCD registers and `busy`, and outputs a 20-bit BCD result plus a 1-cycle `done` pulse. Compiled only under `RPN_DISPLAY_BCD_EN`.
- **Top:** refresh counter, digit mux, blanking logic, output registers.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles → `anodes`=8'hFF, `segments`=7'h7F, `busy`=0. With COUNT_MAX=4 after release → `anodes` steps FE,FD,FB,…,7F every 4 cycles, then wraps to FE.
- **Full conversion (BCD):** `value`=16'hFFFF → `busy` high for exactly 17 cycles; digits 4..0 read 6,5,5,3,5 (7'h02,7'h12,7'h12,7'h30,7'h12).
- **Leading-zero blanking (BCD):** `value`=16'h0101 → digits 2..0 read 2,5,7; digits 3–4 blank (7'h7F). `value`=0 → digit 0 shows 7'h40, digits 1–4 blank.
- **Change mid-conversion:** `value` 16'h0001, then 16'h00FF at cycle 5 of `busy` → first commit shows 1; `busy` re-asserts 1 cycle later; final digits read 255.
- **Reset mid-conversion:** `reset` pulse at cycle 8 of `busy` → `busy`=0 and digit 0 shows 0. The held `value` is then reconverted with a fresh 17-cycle `busy`.
- **Hex mode (macro undefined):** `value`=16'hFE00 → digits 3..0 read F,E,0,0 (7'h0E,7'h06,7'h40,7'h40); `busy` stays 0; `status`=3'd5 → digit 7 shows 7'h12.
